// File: rtl/fetch_pkg.sv
// Shared widths and the queue entry type for the instruction fetch stage.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus plus the decode-facing queue head.
// master = fetch unit, slave = memory/decode side.
interface inst_fetch_unit_if;
    import fetch_pkg::*;

    logic               IMemReqValid;
    logic               IMemReqReady;
    logic [ADDR_W-1:0]  IMemReqAddr;
    logic               IMemRespValid;
    logic [INSTR_W-1:0] IMemRespData;
    logic               IfValid;
    logic               IfReady;
    logic [INSTR_W-1:0] IfInstr;
    logic [ADDR_W-1:0]  IfPC;

    modport master (
        output IMemReqValid, IMemReqAddr, IfValid, IfInstr, IfPC,
        input  IMemReqReady, IMemRespValid, IMemRespData, IfReady
    );

    modport slave (
        input  IMemReqValid, IMemReqAddr, IfValid, IfInstr, IfPC,
        output IMemReqReady, IMemRespValid, IMemRespData, IfReady
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} with flush; head is read straight from storage
// so a pushed entry becomes visible one cycle later.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fetch_entry_t               i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, credit-limits memory requests against queue space,
// and flushes on redirect. Define FETCH_PERF_COUNTERS_EN for push/flush counters.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    inst_fetch_unit_if.master bus
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]       PerfFetched,
    output logic [31:0]       PerfFlushed
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_count;

    logic [CW-1:0]     w_count;
    logic              w_credit;
    logic              w_req_fire;
    logic              w_dropping;
    logic              w_push;
    logic              w_pop;
    logic              w_if_valid;
    logic [ADDR_W-1:0] w_redirect_pc;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;

    // Outstanding requests reserve queue slots, so a response always finds room.
    assign w_credit      = (int'(r_outstanding) + int'(w_count)) < DEPTH;
    assign w_redirect_pc = RedirectPC & ~ADDR_W'(3);
    assign w_req_fire    = bus.IMemReqValid && bus.IMemReqReady;
    assign w_dropping    = bus.IMemRespValid && (r_drop_count != '0);
    assign w_push        = bus.IMemRespValid && !Redirect && (r_drop_count == '0);
    assign w_pop         = w_if_valid && bus.IfReady && !Redirect;
    assign w_push_entry  = '{pc: r_resp_pc, instr: bus.IMemRespData};

    assign bus.IMemReqValid = !Reset && !Redirect && w_credit;
    assign bus.IMemReqAddr  = r_fetch_pc;
    assign bus.IfValid      = w_if_valid;
    assign bus.IfInstr      = w_head.instr;
    assign bus.IfPC         = w_head.pc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else begin
            assert (!(bus.IMemRespValid && int'(w_count) == DEPTH));
            if (Redirect) begin
                // Every response still in flight, or arriving now, belongs to the old path.
                r_fetch_pc    <= w_redirect_pc;
                r_resp_pc     <= w_redirect_pc;
                r_outstanding <= r_outstanding - CW'(bus.IMemRespValid);
                r_drop_count  <= r_outstanding - CW'(bus.IMemRespValid);
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_INC;
                if (w_push)     r_resp_pc  <= r_resp_pc + PC_INC;
                if (w_dropping) r_drop_count <= r_drop_count - CW'(1);
                r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(bus.IMemRespValid);
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_flush (Redirect),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_valid (w_if_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_push);
            r_perf_flushed <= r_perf_flushed
                            + 32'(bus.IMemRespValid && (Redirect || r_drop_count != '0))
                            + (Redirect ? 32'(w_count) : 32'd0);
        end
    end

    assign PerfFetched = r_perf_fetched;
    assign PerfFlushed = r_perf_flushed;
`endif
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage directly downstream of the PC logic. It owns the fetch PC register, issues in-order word requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small queue feeding decode. A taken-branch redirect flushes the queue and discards in-flight responses.

## Interface
- `DEPTH`, 4: queue entries; also caps outstanding memory requests plus queued entries (power of 2, ≥2).
- `RESET_PC`, 64'h0: fetch PC after reset.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: synchronous, active-high reset.
- `Redirect` input 1: taken branch/unconditional; load `RedirectPC`, flush.
- `RedirectPC` input 64: new fetch address from branch target logic.
- `IMemReqValid` output 1: request valid.
- `IMemReqReady` input 1: memory accepts request.
- `IMemReqAddr` output 64: word address requested.
- `IMemRespValid` input 1: in-order response; no backpressure.
- `IMemRespData` input 32: instruction word.
- `IfValid` output 1: queue head valid to decode.
- `IfReady` input 1: decode accepts head.
- `IfInstr` output 32: head instruction.
- `IfPC` output 64: PC of head instruction.

## Operation
- State: `FetchPC`, `RespPC`, `Outstanding` (0..DEPTH), `DropCount` (0..DEPTH), queue of {PC, instr} with `Count`.
- Request: `IMemReqValid = !Redirect && (Outstanding + Count < DEPTH)`; `IMemReqAddr = FetchPC`. Handshake (valid & ready): `FetchPC <= FetchPC + 4` (mod 2^64), `Outstanding++`.
- Response: every `IMemRespValid` decrements `Outstanding`. If `DropCount > 0`: `DropCount--`, discard. Otherwise push {`RespPC`, `IMemRespData`}, `RespPC <= RespPC + 4`.
- Pop: `IfValid & IfReady` removes head. Push and pop in the same cycle both apply; `Count` unchanged.
- Redirect (priority over all else): `FetchPC <= RespPC <= {RedirectPC[63:2], 2'b00}`, queue emptied, `DropCount <= Outstanding - IMemRespValid` (response arriving in the redirect cycle is discarded and counted), `Outstanding <= Outstanding - IMemRespValid`. Decode handshake in the redirect cycle is ignored (entry lost to flush).
- Credit rule guarantees push never occurs with `Count == DEPTH`; a response while full is an assertion failure.
- Simultaneous request handshake and response: `Outstanding` net unchanged.

## Timing
- Reset values: `IMemReqValid=0`, `IMemReqAddr=RESET_PC`, `IfValid=0`, `IfInstr=0`, `IfPC=0`, `Count=Outstanding=DropCount=0`, `FetchPC=RespPC=RESET_PC`. Reset mid-operation discards everything; memory shares `Reset`, so no stale responses follow.
- First request: cycle after reset deassertion.
- Response-to-`IfValid`: 1 cycle (registered queue, no bypass).
- Redirect-to-request at new PC: 1 cycle; `IfValid=0` the cycle after redirect.
- Sustained throughput: 1 instr/cycle when memory latency + 1 ≤ DEPTH and decode always ready.

## Configuration
- `FETCH_PERF_COUNTERS_EN` defined: adds outputs `PerfFetched[31:0]` (queue pushes) and `PerfFlushed[31:0]` (discarded responses + flushed entries), both reset to 0, wrapping.
- Not defined: ports and counters absent; fetch behaviour identical.

## Structure
- Package `fetch_pkg`: `INSTR_W=32`, `ADDR_W=64`, `PC_INC=4`, queue entry typedef {pc, instr}.
- One sub-module: `fetch_queue` (synchronous FIFO with flush, push, pop, count); credit/redirect logic in the top.

## Test plan
- Reset with `RESET_PC=64'h1000`, memory ready, latency 1 → requests 0x1000, 0x1004, 0x1008…; `IfPC`/`IfInstr` match in order, 1 per cycle.
- Hold `IfReady=0` → at most DEPTH=4 requests outstanding+queued, `IMemReqValid` drops, no lost or duplicated instructions on release.
- Redirect to 64'h2000 with 2 outstanding, one response in the redirect cycle → `DropCount=1`, both old responses discarded, next `IfPC=0x2000`.
- `RedirectPC=64'h2003` → fetch from 0x2000.
- `FetchPC=64'hFFFF_FFFF_FFFF_FFFC` → next request address 0x0.
- Redirect and `IfValid&IfReady` same cycle, queue full → queue empty next cycle, `IfValid=0`.
